// File: rtl/posedge_delay_buffer_sync.sv
// Inertial rising-edge delay: z rises after DELAY consecutive high samples of x, falls one edge after x is sampled low.
// All outputs are registered; the rise latency is DELAY edges and the fall latency is one edge.
module posedge_delay_buffer_sync #(
    parameter int DELAY = 5,
    parameter int CW    = $clog2(DELAY + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic x,
    output logic z,
    output logic pending,
    output logic cancel,
    output logic rise,
    output logic fall
);

    typedef enum logic [1:0] {
        LOW  = 2'd0,
        WAIT = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(DELAY - 1);

    if (DELAY < 1 || DELAY > 255) begin : g_bad_delay
        $error("posedge_delay_buffer_sync: DELAY must be in 1..255");
    end
    if (CW != $clog2(DELAY + 1)) begin : g_bad_cw
        $error("posedge_delay_buffer_sync: CW is derived from DELAY and must not be overridden");
    end

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          z_q, z_d;
    logic          pending_q, pending_d;
    logic          cancel_q, cancel_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cancel_d = 1'b0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        case (state_q)
            LOW: begin
                if (x) begin
                    if (DELAY == 1) begin
                        state_d = HIGH;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(1);
                    end
                end
            end
            WAIT: begin
                if (!x) begin
                    state_d  = LOW;
                    cnt_d    = '0;
                    cancel_d = 1'b1;
                end else if (cnt_q == LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (!x) begin
                    state_d = LOW;
                    fall_d  = 1'b1;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
        // Level outputs are registered from the next state so they line up with the strobes.
        z_d       = (state_d == HIGH);
        pending_d = (state_d == WAIT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= LOW;
            cnt_q     <= '0;
            z_q       <= 1'b0;
            pending_q <= 1'b0;
            cancel_q  <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            z_q       <= z_d;
            pending_q <= pending_d;
            cancel_q  <= cancel_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    assign z       = z_q;
    assign pending = pending_q;
    assign cancel  = cancel_q;
    assign rise    = rise_q;
    assign fall    = fall_q;

endmodule

// File: doc/posedge_delay_buffer_sync.md
# posedge_delay_buffer_sync

Synchronous rising-edge delay generator: output `z` follows input `x` but its rising edge is delayed by `DELAY` clock cycles, while its falling edge follows `x` with one-register latency. The delay is inertial: a high pulse on `x` shorter than `DELAY` samples never reaches `z`. The block is the clocked counterpart of the falling-edge delay buffers. It is used wherever a signal must be qualified as stably asserted before it propagates, such as enable sequencing and debounce-like gating. It also provides status strobes for a supervising controller.

## Interface
- `DELAY`, default 5: number of consecutive high samples of `x` required before `z` rises. Legal range 1..255; values outside the range are a configuration error.
- `CW`, default `$clog2(DELAY+1)`: counter width. Derived; do not override.
- `clock` input 1: single clock; all sampling on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `x` input 1: input signal; synchronous to `clock` (no internal synchronizer).
- `z` output 1: delayed signal, registered.
- `pending` output 1: registered; high while a rise is being qualified.
- `cancel` output 1: registered one-cycle strobe; a qualifying rise was aborted by `x` returning low.
- `rise` output 1: registered one-cycle strobe, coincident with the 0->1 transition of `z`.
- `fall` output 1: registered one-cycle strobe, coincident with the 1->0 transition of `z`.

## Operation
- Defining rule: after clock edge n, `z` = 1 iff `x` was sampled 1 at every edge n-DELAY+1 .. n, and none of those edges lies before the last reset deassertion.
- State machine:
  - `LOW`: `z`=0, counter `cnt`=0.
    - `x`=1 with DELAY=1: go to `HIGH`.
    - `x`=1 with DELAY>1: go to `WAIT`, `cnt`=1.
    - `x`=0: stay in `LOW`.
  - `WAIT`: `z`=0, `pending`=1.
    - `x`=1 and `cnt`+1 = DELAY: go to `HIGH`, `cnt`=0.
    - `x`=1 otherwise: `cnt` increments.
    - `x`=0: go to `LOW`, `cnt`=0, pulse `cancel`.
  - `HIGH`: `z`=1.
    - `x`=0: go to `LOW`.
    - `x`=1: stay in `HIGH`; `cnt` stays 0.
- Counter width rule: `cnt` never exceeds DELAY-1 and never wraps. `CW` bits suffice for DELAY=255.
- `pending` is 1 exactly in `WAIT`. It is 0 in `LOW` and `HIGH`.
- `rise` is asserted for the single cycle following the edge of the `WAIT`->`HIGH` transition, or the `LOW`->`HIGH` transition when DELAY=1. `fall` is asserted for the cycle following the `HIGH`->`LOW` transition.
- At most one of `rise`, `fall` and `cancel` is high in any cycle.
- `x` toggling every cycle with DELAY>1: `z` stays 0, `pending` and `cancel` alternate, and no `rise` occurs.
- A new high on `x` after `cancel` restarts qualification from `cnt`=1. There is no credit for earlier samples.
- DELAY=1 degenerates to `z` = `x` registered. `pending` and `cancel` are then never asserted.

## Timing
- Reset values (asynchronous, immediate on `reset` assertion):
  - state `LOW`, `cnt`=0;
  - `z`=0, `pending`=0, `cancel`=0, `rise`=0, `fall`=0.
- Reset mid-operation:
  - in `WAIT`, the qualification is discarded and no `cancel` is produced;
  - in `HIGH`, `z` drops immediately and no `fall` strobe is produced.
- First sampling edge is the first rising edge of `clock` with `reset` low. If `x` is already high at release, `z` rises after DELAY edges, never earlier.
- Rise latency: if `x` is first sampled high at edge k and stays high, `z`=1 after edge k+DELAY-1. That is DELAY edges including k.
- Fall latency: `z`=0 after the first edge sampling `x`=0. This is one register stage, regardless of DELAY.
- All outputs change only on the `clock` rising edge, except on reset assertion. There are no combinational paths from `x` to any output.

## Test plan
- Reset with DELAY=5: assert `reset` mid-cycle, then sample while `x`=1 -> all outputs 0 immediately. After release with `x` held 1, `z`=1 after the 5th edge and `rise` pulses once.
- Clean pulse with DELAY=5: `x` high for 8 edges (k..k+7), then low. Required:
  - `pending`=1 after edges k..k+3;
  - `z`=1 after edges k+4..k+7 and 0 after k+8;
  - `rise` after k+4, `fall` after k+8.
- Short pulse with DELAY=5: `x` high for 4 edges, then low -> `z` stays 0, `pending` high 4 cycles, `cancel` pulses once after the 5th edge, no `rise`.
- Toggle with DELAY=5: `x` alternates every edge for 20 edges -> `z` never 1, 10 `cancel` pulses, `pending` and `cancel` never both high.
- DELAY=1: random `x` for 100 edges -> `z` equals `x` delayed one edge, `pending` and `cancel` always 0.
- DELAY=255: `x` high 254 edges, then low, then high 255 edges -> one `cancel`, `z` rises after the 255th edge of the second burst, `cnt` never wraps.
